digital_clock_core: RTL and testbench

//  Parametrised hours/minutes/seconds timekeeping core for the board display clock.
//  A prescaler derives a 1-cycle tick from clk, and cascaded sec/min/hour counters advance on each tick.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/clk_prescaler.sv | 31 +++
 rtl/digital_clock_core.sv | 138 +++++++++++++
 tb/tb_digital_clock_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock core: FSM state encoding
// (equal to the set_field display code) and time-field widths/limits.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  // +1 with wrap back to zero after max
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Divides clk by CLK_HZ/TICK_HZ and emits a 1-cycle tick while counting.
// The counter holds when run is low; clear forces it back to zero.
module clk_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Combinational so the counters see tick on the same edge the count wraps
  assign tick = run && !rst && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/digital_clock_core.sv
// Hours/minutes/seconds timekeeping core with pause and H->M->S set mode.
// Optional alarm enabled by defining DIGITAL_CLOCK_ALARM_EN.
module digital_clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int HOUR_MAX   = 24,
  parameter int ALARM_SECS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       set_btn,
  input  logic       inc,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  input  logic       alarm_ack,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       tick,
  output logic [1:0] set_field,
  output logic       alarm
);

  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

  state_t              state_reg, state_next;
  logic [SEC_W-1:0]    sec_reg, sec_next;
  logic [MIN_W-1:0]    min_reg, min_next;
  logic [HOUR_W-1:0]   hour_reg, hour_next, hour_inc;
  logic                run, clear, tick_w;

  assign run   = (state_reg == RUN) && !pause;
  assign clear = (state_reg == SET_S) && set_btn;

  clk_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .tick  (tick_w)
  );

  assign hour_inc = (hour_reg == HOUR_LAST) ? '0 : hour_reg + 5'd1;

  // set_btn takes priority over inc within a set state
  always_comb begin
    state_next = state_reg;
    sec_next   = sec_reg;
    min_next   = min_reg;
    hour_next  = hour_reg;
    unique case (state_reg)
      RUN: begin
        if (set_btn) state_next = SET_H;
        if (tick_w) begin
          sec_next = wrap_inc(sec_reg, SEC_MAX);
          if (sec_reg == SEC_MAX) begin
            min_next = wrap_inc(min_reg, MIN_MAX);
            if (min_reg == MIN_MAX) hour_next = hour_inc;
          end
        end
      end
      SET_H: begin
        if (set_btn)  state_next = SET_M;
        else if (inc) hour_next  = hour_inc;
      end
      SET_M: begin
        if (set_btn)  state_next = SET_S;
        else if (inc) min_next   = wrap_inc(min_reg, MIN_MAX);
      end
      SET_S: begin
        if (set_btn)  state_next = RUN;
        else if (inc) sec_next   = wrap_inc(sec_reg, SEC_MAX);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      sec_reg   <= '0;
      min_reg   <= '0;
      hour_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sec_reg   <= sec_next;
      min_reg   <= min_next;
      hour_reg  <= hour_next;
    end
  end

  assign sec       = sec_reg;
  assign min       = min_reg;
  assign hour      = hour_reg;
  assign tick      = tick_w;
  assign set_field = state_reg;

`ifdef DIGITAL_CLOCK_ALARM_EN
  localparam int AW = $clog2(ALARM_SECS + 1);

  logic          alarm_reg;
  logic [AW-1:0] alarm_cnt_reg;
  logic          alarm_hit;

  // tick only exists in RUN, so the match is implicitly RUN-only
  assign alarm_hit = tick_w && (hour_next == alarm_h) &&
                     (min_next == alarm_m) && (sec_next == '0);

  always_ff @(posedge clk) begin
    if (rst || alarm_ack) begin
      alarm_reg     <= 1'b0;
      alarm_cnt_reg <= '0;
    end else if (alarm_hit) begin
      alarm_reg     <= 1'b1;
      alarm_cnt_reg <= '0;
    end else if (alarm_reg && tick_w) begin
      if (alarm_cnt_reg == AW'(ALARM_SECS - 1)) begin
        alarm_reg     <= 1'b0;
        alarm_cnt_reg <= '0;
      end else begin
        alarm_cnt_reg <= alarm_cnt_reg + 1'b1;
      end
    end
  end

  assign alarm = alarm_reg;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_h, alarm_m, alarm_ack} ^ (ALARM_SECS > 0);
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_digital_clock_core.sv
// Directed bench for digital_clock_core with DIV = 4 and a 3-tick alarm.
// Alarm checks are built when DIGITAL_CLOCK_ALARM_EN is defined.
module tb_digital_clock_core;

  logic       clk = 1'b0;
  logic       rst, pause, set_btn, inc, alarm_ack;
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       tick, alarm;
  logic [1:0] set_field;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digital_clock_core #(
    .CLK_HZ     (4),
    .TICK_HZ    (1),
    .HOUR_MAX   (24),
    .ALARM_SECS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pause     (pause),
    .set_btn   (set_btn),
    .inc       (inc),
    .alarm_h   (alarm_h),
    .alarm_m   (alarm_m),
    .alarm_ack (alarm_ack),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .tick      (tick),
    .set_field (set_field),
    .alarm     (alarm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    return (h << 12) | (m << 6) | s;
  endfunction

  function automatic logic [31:0] now();
    return {15'd0, hour, min, sec};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic b, input logic i);
    set_btn = b;
    inc     = i;
    step();
    set_btn = 1'b0;
    inc     = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; set_btn = 1'b0; inc = 1'b0;
    alarm_ack = 1'b0; alarm_h = 5'd0; alarm_m = 6'd1;
    step();
    check("reset_time", now(), hms(0, 0, 0));
    check("reset_field", {30'd0, set_field}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    check("reset_alarm", {31'd0, alarm}, 32'd0);
    rst = 1'b0;

    // 1: ticks at cycles 4, 8, 12
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("run_tick_c%0d", c), {31'd0, tick}, {31'd0, (c % 4) == 0});
      step();
    end
    check("run_12cyc", now(), hms(0, 0, 3));
    check("run_alarm_idle", {31'd0, alarm}, 32'd0);

    // 2: preset 23:59:59 then roll over
    press(1'b1, 1'b0);
    check("seth_field", {30'd0, set_field}, 32'd1);
    check("seth_no_tick", {31'd0, tick}, 32'd0);
    incs(23);
    press(1'b1, 1'b0);
    incs(59);
    press(1'b1, 1'b0);
    incs(56);
    check("preset", now(), hms(23, 59, 59));
    press(1'b1, 1'b0);
    check("back_run", {30'd0, set_field}, 32'd0);
    step(); step(); step();
    check("pre_wrap_time", now(), hms(23, 59, 59));
    check("pre_wrap_tick", {31'd0, tick}, 32'd1);
    step();
    check("wrap_midnight", now(), hms(0, 0, 0));

    // 3: pause mid-count with cnt = 2
    step(); step();
    pause = 1'b1;
    begin
      int ticks_seen = 0;
      for (int k = 0; k < 20; k++) begin
        ticks_seen += int'(tick);
        step();
      end
      check("pause_ticks", ticks_seen, 0);
    end
    check("pause_time", now(), hms(0, 0, 0));
    pause = 1'b0;
    check("resume_no_tick", {31'd0, tick}, 32'd0);
    step();
    check("resume_tick", {31'd0, tick}, 32'd1);
    step();
    check("resume_time", now(), hms(0, 0, 1));

    // 4: set hour 5 -> 8, min 0 -> 1 via 61 incs, set_btn beats inc
    press(1'b1, 1'b0);
    incs(5);
    check("hour5", now(), hms(5, 0, 1));
    incs(3);
    check("hour8", now(), hms(8, 0, 1));
    press(1'b1, 1'b0);
    incs(61);
    check("min_wrap", now(), hms(8, 1, 1));
    press(1'b1, 1'b1);
    check("btn_beats_inc_field", {30'd0, set_field}, 32'd3);
    check("btn_beats_inc_time", now(), hms(8, 1, 1));
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("inc_in_run", now(), hms(8, 1, 1));

    // 5: reset wins mid set mode
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    incs(29);
    check("setm_30", now(), hms(8, 30, 1));
    check("setm_field", {30'd0, set_field}, 32'd2);
    rst = 1'b1; set_btn = 1'b1; inc = 1'b1;
    step();
    rst = 1'b0; set_btn = 1'b0; inc = 1'b0;
    check("rst_set_time", now(), hms(0, 0, 0));
    check("rst_set_field", {30'd0, set_field}, 32'd0);

`ifdef DIGITAL_CLOCK_ALARM_EN
    // 6: alarm at 00:01, lasting 3 ticks, then ack path
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    incs(59);
    press(1'b1, 1'b0);
    step(); step(); step();
    check("alarm_before", {31'd0, alarm}, 32'd0);
    step();
    check("alarm_time", now(), hms(0, 1, 0));
    check("alarm_rise", {31'd0, alarm}, 32'd1);
    for (int k = 0; k < 8; k++) step();
    check("alarm_hold_2t", {31'd0, alarm}, 32'd1);
    for (int k = 0; k < 4; k++) step();
    check("alarm_timeout", {31'd0, alarm}, 32'd0);
    check("alarm_timeout_time", now(), hms(0, 1, 3));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    incs(59);
    press(1'b1, 1'b0);
    incs(56);
    press(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    check("alarm_rise2", {31'd0, alarm}, 32'd1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    check("alarm_ack", {31'd0, alarm}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
